// File: rtl/led_pattern_sequencer.sv
// Animated 8-LED bar driver (OFF/SCAN/FILL/BLINK) with a programmable step rate.
// Mode/rate commands are staged in a pending slot and only take effect on a step boundary.
module led_pattern_sequencer #(
    parameter int DIV_W        = 23,
    parameter int DEFAULT_DIV  = 1499999,
    parameter int DEFAULT_MODE = 1
) (
    input  logic             CLKIN,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_MODE,
    input  logic [DIV_W-1:0] CMD_DIV,
    output logic [8:1]       LED,
    output logic             STEP
);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_SCAN  = 2'd1;
    localparam logic [1:0] MODE_FILL  = 2'd2;
    localparam logic [1:0] MODE_BLINK = 2'd3;

    localparam logic [1:0]       RST_MODE = DEFAULT_MODE[1:0];
    localparam logic [DIV_W-1:0] RST_DIV  = DEFAULT_DIV[DIV_W-1:0];

    // pos doubles as the FILL level minus one and as the BLINK phase bit
    function automatic logic [7:0] pattern(input logic [1:0] mode, input logic [2:0] pos);
        logic [7:0] leds;
        case (mode)
            MODE_SCAN:  leds = 8'h01 << pos;
            MODE_FILL:  leds = 8'hFF >> (3'd7 - pos);
            MODE_BLINK: leds = pos[0] ? 8'h00 : 8'hFF;
            default:    leds = 8'h00;
        endcase
        return leds;
    endfunction

    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pos_q, pos_d;
    logic             dir_up_q, dir_up_d;
    logic             pend_vld_q, pend_vld_d;
    logic [1:0]       pend_mode_q, pend_mode_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             ready_q, ready_d;
    logic [7:0]       led_q, led_d;
    logic             step_q, step_d;

    logic             tick;
    logic             accept;
    logic [2:0]       pos_adv;
    logic             dir_up_adv;

    assign tick   = (cnt_q == div_q);
    assign accept = CMD_VALID && ready_q;

    // Next pattern position for an ordinary step; ends of the bounce are shown once
    always_comb begin
        pos_adv    = pos_q;
        dir_up_adv = dir_up_q;
        case (mode_q)
            MODE_SCAN, MODE_FILL: begin
                if (dir_up_q) begin
                    pos_adv    = pos_q + 3'd1;
                    dir_up_adv = (pos_adv != 3'd7);
                end else begin
                    pos_adv    = pos_q - 3'd1;
                    dir_up_adv = (pos_adv == 3'd0);
                end
            end
            MODE_BLINK: pos_adv = {2'b00, ~pos_q[0]};
            default: begin
                pos_adv    = pos_q;
                dir_up_adv = dir_up_q;
            end
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        div_d       = div_q;
        cnt_d       = cnt_q + 1'b1;
        pos_d       = pos_q;
        dir_up_d    = dir_up_q;
        pend_vld_d  = pend_vld_q;
        pend_mode_d = pend_mode_q;
        pend_div_d  = pend_div_q;
        led_d       = led_q;
        step_d      = tick;

        if (tick) begin
            cnt_d = '0;
            if (pend_vld_q) begin
                mode_d     = pend_mode_q;
                div_d      = pend_div_q;
                pos_d      = 3'd0;
                dir_up_d   = 1'b1;
                led_d      = pattern(pend_mode_q, 3'd0);
                pend_vld_d = 1'b0;
            end else begin
                pos_d    = pos_adv;
                dir_up_d = dir_up_adv;
                led_d    = pattern(mode_q, pos_adv);
            end
        end

        // A command arriving on a tick edge cannot be applied by that same tick:
        // accept only happens while the slot is empty, and apply needs it full.
        if (accept) begin
            pend_vld_d  = 1'b1;
            pend_mode_d = CMD_MODE;
            pend_div_d  = CMD_DIV;
        end

        ready_d = !pend_vld_d;
    end

    always_ff @(posedge CLKIN) begin
        if (RST) begin
            mode_q      <= RST_MODE;
            div_q       <= RST_DIV;
            cnt_q       <= '0;
            pos_q       <= 3'd0;
            dir_up_q    <= 1'b1;
            pend_vld_q  <= 1'b0;
            pend_mode_q <= 2'd0;
            pend_div_q  <= '0;
            ready_q     <= 1'b1;
            led_q       <= pattern(RST_MODE, 3'd0);
            step_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            dir_up_q    <= dir_up_d;
            pend_vld_q  <= pend_vld_d;
            pend_mode_q <= pend_mode_d;
            pend_div_q  <= pend_div_d;
            ready_q     <= ready_d;
            led_q       <= led_d;
            step_q      <= step_d;
        end
    end

    assign CMD_READY = ready_q;
    assign LED       = led_q;
    assign STEP      = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed scenarios plus random commands/resets,
// all checked each cycle against a step-index based reference model.
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [22:0] cmd_div;
    logic [8:1]  led;
    logic        step;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_mode, m_div, m_cnt, m_idx, m_pmode, m_pdiv;
    bit m_pend, m_ready, m_step;

    logic [7:0] scan_tab [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .DIV_W        (23),
        .DEFAULT_DIV  (3),
        .DEFAULT_MODE (1)
    ) dut (
        .CLKIN     (clk),
        .RST       (rst),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_MODE  (cmd_mode),
        .CMD_DIV   (cmd_div),
        .LED       (led),
        .STEP      (step)
    );

    // LED contents idx steps after a mode was entered
    function automatic logic [7:0] exp_led(input int mode, input int idx);
        int s = idx % 14;
        int p = (s <= 7) ? s : 14 - s;
        case (mode)
            1:       return 8'(1 << p);
            2:       return 8'((1 << (p + 1)) - 1);
            3:       return ((idx % 2) == 0) ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 1;
        m_div   = 3;
        m_cnt   = 0;
        m_idx   = 0;
        m_pend  = 0;
        m_pmode = 0;
        m_pdiv  = 0;
        m_ready = 1;
        m_step  = 0;
    endtask

    task automatic model_edge();
        bit tick;
        bit acc;
        if (rst) begin
            model_reset();
        end else begin
            tick = (m_cnt == m_div);
            acc  = cmd_valid && m_ready;
            if (tick) begin
                m_cnt  = 0;
                m_step = 1;
                if (m_pend) begin
                    m_mode = m_pmode;
                    m_div  = m_pdiv;
                    m_idx  = 0;
                    m_pend = 0;
                end else begin
                    m_idx++;
                end
            end else begin
                m_cnt++;
                m_step = 0;
            end
            if (acc) begin
                m_pend  = 1;
                m_pmode = int'(cmd_mode);
                m_pdiv  = int'(cmd_div);
            end
            m_ready = !m_pend;
        end
    endtask

    // one clock: model follows the edge, outputs checked 1 time unit later, return at negedge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("led",   32'(led),       32'(exp_led(m_mode, m_idx)));
            chk("step",  32'(step),      32'(m_step));
            chk("ready", 32'(cmd_ready), 32'(m_ready));
            @(negedge clk);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!cmd_ready && w < 100) begin
            cyc(1);
            w++;
        end
        chk("ready_timeout", 32'(w < 100), 32'd1);
    endtask

    task automatic send(input logic [1:0] mode, input logic [22:0] div);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_div   = div;
        cyc(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int w;
        model_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_div   = '0;
        @(negedge clk);
        cyc(2);
        rst = 1'b0;

        chk("rst_led",   32'(led),       32'h01);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_step",  32'(step),      32'd0);

        // default SCAN sequence, one entry per STEP pulse
        for (int k = 1; k < 16; k++) begin
            w = 0;
            do begin
                cyc(1);
                w++;
            end while (!step && w < 20);
            chk("scan_wait", 32'(w <= 4), 32'd1);
            chk("scan_seq",  32'(led),    32'(scan_tab[k]));
        end

        // FILL at div 1
        send(2'd2, 23'd1);
        chk("ready_low_after_accept", 32'(cmd_ready), 32'd0);
        cyc(40);

        // BLINK at div 0: STEP continuously high
        wait_ready();
        send(2'd3, 23'd0);
        cyc(20);
        chk("blink_step_high", 32'(step), 32'd1);

        // back to SCAN div 3, then a command landing exactly on a tick edge
        wait_ready();
        send(2'd1, 23'd3);
        wait_ready();
        cyc(2);
        w = 0;
        while (m_cnt != m_div && w < 10) begin
            cyc(1);
            w++;
        end
        cmd_valid = 1'b1;
        cmd_mode  = 2'd2;
        cmd_div   = 23'd2;
        cyc(1);
        chk("tick_accept_step", 32'(step), 32'd1);
        // a second offer while busy must be ignored
        cmd_mode = 2'd0;
        cmd_div  = 23'd1;
        cyc(3);
        cmd_valid = 1'b0;
        cyc(1);
        chk("late_apply_led",  32'(led),  32'h01);
        chk("late_apply_step", 32'(step), 32'd1);
        cyc(1);
        chk("late_apply_ready", 32'(cmd_ready), 32'd1);
        cyc(12);

        // pending command discarded by reset
        wait_ready();
        send(2'd3, 23'd5);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_rst_led",   32'(led),       32'h01);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        cyc(20);

        // OFF keeps stepping
        wait_ready();
        send(2'd0, 23'd2);
        cyc(20);

        // random commands, rates and occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_mode  = 2'($urandom_range(0, 3));
            cmd_div   = 23'($urandom_range(0, 4));
            cyc(1);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cyc(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
